// File: rtl/perf_monitor.sv
// Performance monitor: a free-running cycle counter plus per-channel event counters
// with saturation flags, a run-limit halt, a snapshot bank and a registered readout port.
module perf_monitor #(
    parameter int NUM_EVT = 2,
    parameter int CNT_W   = 32,
    parameter int SEL_W   = $clog2(NUM_EVT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic               clr_i,
    input  logic [NUM_EVT-1:0] evt_i,
    input  logic [NUM_EVT-1:0] inh_i,
    input  logic [CNT_W-1:0]   cycle_limit_i,
    input  logic               snap_i,
    input  logic [SEL_W-1:0]   rd_sel_i,
    output logic [CNT_W-1:0]   rd_data_o,
    output logic [NUM_EVT:0]   ovf_o,
    output logic               halt_o
);

    logic [CNT_W-1:0] cycCnt_q, cycCnt_d;
    logic [CNT_W-1:0] evtCnt_q [NUM_EVT];
    logic [CNT_W-1:0] evtCnt_d [NUM_EVT];
    logic [CNT_W-1:0] snap_q   [NUM_EVT+1];
    logic [CNT_W-1:0] snap_d   [NUM_EVT+1];
    logic [CNT_W-1:0] rdData_q, rdData_d;
    logic [NUM_EVT:0] ovf_q, ovf_d;
    logic             halt_q, halt_d;
    logic             active;
    logic [CNT_W-1:0] cycInc;

    assign active = en_i & ~halt_q & ~clr_i;
    assign cycInc = cycCnt_q + CNT_W'(1);

    // Halt is only raised by the increment landing on the limit, so lowering the
    // limit below the current count never trips it.
    always_comb begin
        cycCnt_d = cycCnt_q;
        ovf_d    = ovf_q;
        halt_d   = halt_q;
        for (int k = 0; k < NUM_EVT; k++) begin
            evtCnt_d[k] = evtCnt_q[k];
        end

        if (clr_i) begin
            cycCnt_d = '0;
            ovf_d    = '0;
            halt_d   = 1'b0;
            for (int k = 0; k < NUM_EVT; k++) begin
                evtCnt_d[k] = '0;
            end
        end else if (active) begin
            if (&cycCnt_q) begin
                ovf_d[0] = 1'b1;
            end else begin
                cycCnt_d = cycInc;
                if ((cycle_limit_i != '0) && (cycInc == cycle_limit_i)) begin
                    halt_d = 1'b1;
                end
            end
            for (int k = 0; k < NUM_EVT; k++) begin
                if (evt_i[k] && !inh_i[k]) begin
                    if (&evtCnt_q[k]) begin
                        ovf_d[k+1] = 1'b1;
                    end else begin
                        evtCnt_d[k] = evtCnt_q[k] + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Snapshot captures the pre-update live values, so snap with clr keeps the old counts.
    always_comb begin
        for (int k = 0; k <= NUM_EVT; k++) begin
            snap_d[k] = snap_q[k];
        end
        if (snap_i) begin
            snap_d[0] = cycCnt_q;
            for (int k = 0; k < NUM_EVT; k++) begin
                snap_d[k+1] = evtCnt_q[k];
            end
        end
    end

    always_comb begin
        rdData_d = '0;
        for (int k = 0; k <= NUM_EVT; k++) begin
            if (rd_sel_i == SEL_W'(k)) begin
                rdData_d = snap_q[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycCnt_q <= '0;
            rdData_q <= '0;
            ovf_q    <= '0;
            halt_q   <= 1'b0;
            for (int k = 0; k < NUM_EVT; k++) begin
                evtCnt_q[k] <= '0;
            end
            for (int k = 0; k <= NUM_EVT; k++) begin
                snap_q[k] <= '0;
            end
        end else begin
            cycCnt_q <= cycCnt_d;
            rdData_q <= rdData_d;
            ovf_q    <= ovf_d;
            halt_q   <= halt_d;
            for (int k = 0; k < NUM_EVT; k++) begin
                evtCnt_q[k] <= evtCnt_d[k];
            end
            for (int k = 0; k <= NUM_EVT; k++) begin
                snap_q[k] <= snap_d[k];
            end
        end
    end

    assign rd_data_o = rdData_q;
    assign ovf_o     = ovf_q;
    assign halt_o    = halt_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Self-checking bench for perf_monitor: directed vector table, hand-written corner
// sequences, then a randomized run against an integer reference model.
module tb_perf_monitor;

    localparam int NUM_EVT = 2;
    localparam int CNT_W   = 8;
    localparam int SEL_W   = $clog2(NUM_EVT + 1);
    localparam int MAXV    = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_i = 1'b1;
    logic               en_i = 1'b0;
    logic               clr_i = 1'b0;
    logic [NUM_EVT-1:0] evt_i = '0;
    logic [NUM_EVT-1:0] inh_i = '0;
    logic [CNT_W-1:0]   cycle_limit_i = '0;
    logic               snap_i = 1'b0;
    logic [SEL_W-1:0]   rd_sel_i = '0;
    logic [CNT_W-1:0]   rd_data_o;
    logic [NUM_EVT:0]   ovf_o;
    logic               halt_o;

    int checks = 0;
    int failures = 0;

    // Reference model state, kept as plain integers
    int             mCyc;
    int             mEvt  [NUM_EVT];
    int             mSnap [NUM_EVT+1];
    int             mRd;
    logic [NUM_EVT:0] mOvf;
    logic           mHalt;

    perf_monitor #(
        .NUM_EVT(NUM_EVT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .evt_i        (evt_i),
        .inh_i        (inh_i),
        .cycle_limit_i(cycle_limit_i),
        .snap_i       (snap_i),
        .rd_sel_i     (rd_sel_i),
        .rd_data_o    (rd_data_o),
        .ovf_o        (ovf_o),
        .halt_o       (halt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_EVT-1:0] evt;
        logic [NUM_EVT-1:0] inh;
        int                 cycles;
        int                 expCyc;
        int                 expCh0;
        int                 expCh1;
        logic [NUM_EVT:0]   expOvf;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Advances the model by one edge from the inputs currently applied
    task automatic modelUpdate();
        int nRd;
        if (rst_i) begin
            mCyc = 0;
            mRd = 0;
            mOvf = '0;
            mHalt = 1'b0;
            for (int k = 0; k < NUM_EVT; k++) mEvt[k] = 0;
            for (int k = 0; k <= NUM_EVT; k++) mSnap[k] = 0;
        end else begin
            nRd = (int'(rd_sel_i) <= NUM_EVT) ? mSnap[rd_sel_i] : 0;
            if (snap_i) begin
                mSnap[0] = mCyc;
                for (int k = 0; k < NUM_EVT; k++) mSnap[k+1] = mEvt[k];
            end
            if (clr_i) begin
                mCyc = 0;
                mOvf = '0;
                mHalt = 1'b0;
                for (int k = 0; k < NUM_EVT; k++) mEvt[k] = 0;
            end else if (en_i && !mHalt) begin
                if (mCyc == MAXV) begin
                    mOvf[0] = 1'b1;
                end else begin
                    mCyc = mCyc + 1;
                    if (cycle_limit_i != 0 && mCyc == int'(cycle_limit_i)) mHalt = 1'b1;
                end
                for (int k = 0; k < NUM_EVT; k++) begin
                    if (evt_i[k] && !inh_i[k]) begin
                        if (mEvt[k] == MAXV) mOvf[k+1] = 1'b1;
                        else mEvt[k] = mEvt[k] + 1;
                    end
                end
            end
            mRd = nRd;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic en, input logic clr, input logic snap,
                                 input logic [NUM_EVT-1:0] evt, input logic [NUM_EVT-1:0] inh,
                                 input logic [CNT_W-1:0] lim, input logic [SEL_W-1:0] sel);
        rst_i = rst;
        en_i = en;
        clr_i = clr;
        snap_i = snap;
        evt_i = evt;
        inh_i = inh;
        cycle_limit_i = lim;
        rd_sel_i = sel;
        @(posedge clk);
        modelUpdate();
        #1;
    endtask

    task automatic idle(input logic [SEL_W-1:0] sel);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0, sel);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic doSnap();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0, '0);
    endtask

    initial begin
        vecs[0] = '{evt: 2'b01, inh: 2'b00, cycles: 10,  expCyc: 10,  expCh0: 10,  expCh1: 0,   expOvf: 3'b000};
        vecs[1] = '{evt: 2'b11, inh: 2'b10, cycles: 5,   expCyc: 5,   expCh0: 5,   expCh1: 0,   expOvf: 3'b000};
        vecs[2] = '{evt: 2'b10, inh: 2'b00, cycles: 7,   expCyc: 7,   expCh0: 0,   expCh1: 7,   expOvf: 3'b000};
        vecs[3] = '{evt: 2'b11, inh: 2'b11, cycles: 4,   expCyc: 4,   expCh0: 0,   expCh1: 0,   expOvf: 3'b000};
        vecs[4] = '{evt: 2'b11, inh: 2'b00, cycles: 300, expCyc: 255, expCh0: 255, expCh1: 255, expOvf: 3'b111};
        vecs[5] = '{evt: 2'b00, inh: 2'b00, cycles: 0,   expCyc: 0,   expCh0: 0,   expCh1: 0,   expOvf: 3'b000};

        // Directed table: reset, count, snapshot, read every select value
        for (int i = 0; i < 6; i++) begin
            doReset();
            checkOutput("reset_rd", 64'(rd_data_o), 64'd0);
            checkOutput("reset_ovf", 64'(ovf_o), 64'd0);
            checkOutput("reset_halt", 64'(halt_o), 64'd0);
            for (int c = 0; c < vecs[i].cycles; c++) begin
                applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, vecs[i].evt, vecs[i].inh, '0, '0);
            end
            doSnap();
            checkOutput("vec_ovf", 64'(ovf_o), 64'(vecs[i].expOvf));
            for (int s = 0; s < 4; s++) begin
                int exp;
                exp = (s == 0) ? vecs[i].expCyc : (s == 1) ? vecs[i].expCh0 :
                      (s == 2) ? vecs[i].expCh1 : 0;
                idle(SEL_W'(s));
                checkOutput("vec_rd", 64'(rd_data_o), 64'(exp));
            end
        end

        // Saturation then clear
        doReset();
        for (int c = 0; c < 300; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, '0, '0, '0);
        checkOutput("sat_ovf", 64'(ovf_o), 64'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
        checkOutput("clr_ovf", 64'(ovf_o), 64'd0);
        doSnap();
        idle(SEL_W'(1));
        checkOutput("clr_ch0", 64'(rd_data_o), 64'd0);

        // Halt at limit 64, nothing counted afterwards
        doReset();
        for (int c = 1; c <= 70; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, '0, CNT_W'(64), '0);
            checkOutput("halt_rise", 64'(halt_o), (c >= 64) ? 64'd1 : 64'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, CNT_W'(64), '0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, CNT_W'(64), SEL_W'(0));
        checkOutput("halt_cyc", 64'(rd_data_o), 64'd64);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, CNT_W'(64), SEL_W'(1));
        checkOutput("halt_ch0", 64'(rd_data_o), 64'd64);

        // Lowering the limit to or below the count never halts
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
        checkOutput("clr_halt", 64'(halt_o), 64'd0);
        for (int c = 0; c < 10; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, CNT_W'(5), '0);
            checkOutput("low_limit", 64'(halt_o), 64'd0);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, CNT_W'(13), '0);
        checkOutput("eq_limit", 64'(halt_o), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, CNT_W'(16), '0);
        checkOutput("pre_limit", 64'(halt_o), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, CNT_W'(16), '0);
        checkOutput("hit_limit", 64'(halt_o), 64'd1);

        // Snap and clear together
        doReset();
        for (int c = 0; c < 37; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
        idle(SEL_W'(0));
        checkOutput("snapclr_snap", 64'(rd_data_o), 64'd37);
        doSnap();
        idle(SEL_W'(0));
        checkOutput("snapclr_live", 64'(rd_data_o), 64'd1);

        // Reset in the middle of a run
        doReset();
        for (int c = 0; c < 20; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, '0, '0, '0);
        doSnap();
        idle(SEL_W'(1));
        checkOutput("midrun_pre", 64'(rd_data_o), 64'd20);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 2'b11, '0, '0, SEL_W'(1));
        checkOutput("midrun_rd", 64'(rd_data_o), 64'd0);
        checkOutput("midrun_ovf", 64'(ovf_o), 64'd0);
        checkOutput("midrun_halt", 64'(halt_o), 64'd0);
        for (int s = 0; s < 3; s++) begin
            idle(SEL_W'(s));
            checkOutput("midrun_snap", 64'(rd_data_o), 64'd0);
        end
        for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 2'b01, '0, '0, '0);
        doSnap();
        idle(SEL_W'(0));
        checkOutput("restart_cyc", 64'(rd_data_o), 64'd3);
        idle(SEL_W'(1));
        checkOutput("restart_ch0", 64'(rd_data_o), 64'd3);

        // Randomized run against the model
        doReset();
        begin
            logic [CNT_W-1:0] lim;
            lim = '0;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 99) == 0) begin
                    lim = ($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 120));
                end
                applyStimulus(($urandom_range(0, 299) == 0),
                              ($urandom_range(0, 3) != 0),
                              ($urandom_range(0, 199) == 0),
                              ($urandom_range(0, 7) == 0),
                              NUM_EVT'($urandom),
                              ($urandom_range(0, 3) == 0) ? NUM_EVT'($urandom) : '0,
                              lim,
                              SEL_W'($urandom_range(0, 3)));
                checkOutput("rand_rd", 64'(rd_data_o), 64'(mRd));
                checkOutput("rand_ovf", 64'(ovf_o), 64'(mOvf));
                checkOutput("rand_halt", 64'(halt_o), 64'(mHalt));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/perf_monitor.md
PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameters SHALL be exactly:
- NUM_EVT, 2, number of event channels (1..16).
- CNT_W, 32, counter width in bits (8..64).
- SEL_W, $clog2(NUM_EVT+1), readout select width.

REQ-002 Ports SHALL be exactly:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- en_i  input  1  global count enable.
- clr_i  input  1  synchronous clear of live counters, overflow flags and halt.
- evt_i  input  NUM_EVT  per-channel event, one count per cycle high.
- inh_i  input  NUM_EVT  per-channel inhibit; event ignored while high.
- cycle_limit_i  input  CNT_W  cycle count at which halt asserts; 0 = unlimited.
- snap_i  input  1  copy live counters into snapshot bank.
- rd_sel_i  input  SEL_W  readout select: 0 = cycle counter, k = event channel k-1.
- rd_data_o  output  CNT_W  registered snapshot value selected by rd_sel_i.
- ovf_o  output  NUM_EVT+1  sticky saturation flags: bit 0 = cycle counter, bit k = channel k-1.
- halt_o  output  1  sticky run-limit reached.

REQ-003 Clock SHALL be clk_i; reset SHALL be rst_i, synchronous and active-high.

Function
REQ-004 Live state SHALL be:
- one CNT_W cycle counter;
- NUM_EVT CNT_W event counters;
- NUM_EVT+1 snapshot registers.

REQ-005 Counting SHALL be active in a cycle iff en_i=1, halt_o=0, clr_i=0 and rst_i=0.

REQ-006 When active, the cycle counter SHALL increment by 1.

REQ-007 When active, event counter k SHALL increment by 1 iff evt_i[k]=1 and inh_i[k]=0.

REQ-008 Saturation:
- A counter at all-ones SHALL hold at all-ones; no wrap.
- Its ovf_o bit SHALL set on the edge where the increment was suppressed.
- ovf_o bits are sticky until clr_i or rst_i.

REQ-009 Halt:
- halt_o SHALL assert on the edge where the cycle counter's new value equals cycle_limit_i and cycle_limit_i != 0.
- halt_o stays high until clr_i or rst_i.
- While halt_o=1 no counter changes.

REQ-010 A change of cycle_limit_i to a value at or below the current cycle count SHALL NOT assert halt_o; only the equality on increment does.

REQ-011 snap_i=1 SHALL load every snapshot register with the live counter value present before that edge's update; the snapshot bank is otherwise unchanged.

REQ-012 clr_i=1 SHALL zero the cycle counter, all event counters, ovf_o and halt_o on that edge. Snapshot registers are not cleared.

REQ-013 snap_i and clr_i high in the same cycle SHALL snapshot the pre-clear values and clear the live state.

REQ-014 rd_data_o SHALL equal the snapshot selected by rd_sel_i, registered: one cycle latency from rd_sel_i and from snapshot update.

REQ-015 rd_sel_i > NUM_EVT SHALL yield rd_data_o = 0.

REQ-016 The block SHALL be fully synthesizable: no hierarchical references and no simulation-only constructs.

Reset
REQ-017 rst_i=1 SHALL, on the edge, zero all live counters, all snapshot registers, rd_data_o, ovf_o and halt_o.

REQ-018 rst_i SHALL take priority over clr_i, snap_i and counting.

REQ-019 Reset asserted mid-run SHALL discard all counts, with no partial snapshot.

REQ-020 From the first edge after rst_i deasserts, counting SHALL resume per REQ-005.

Verification
REQ-021 Basic count: NUM_EVT=2, en_i=1, limit 0, evt_i=2'b01 for 10 cycles, snap, rd_sel_i=1 -> rd_data_o=10 one cycle later; rd_sel_i=2 -> 0; rd_sel_i=0 -> 10.

REQ-022 Inhibit: evt_i=2'b11, inh_i=2'b10 for 5 cycles -> channel 0 = 5, channel 1 = 0.

REQ-023 Halt: cycle_limit_i=64, en_i=1 from reset.
- halt_o rises on the edge the cycle counter reaches 64.
- The counter reads 64 in the snapshot and never 65.
- Events after halt are not counted.

REQ-024 Saturation: CNT_W=8, event held high for 300 cycles -> channel reads 255, ovf_o[1]=1; clr_i -> counter 0, ovf_o=0.

REQ-025 Simultaneous snap and clr: cycle counter at 37 with snap_i=clr_i=1 -> snapshot 0 = 37, live counter 0, next-cycle count 1.

REQ-026 Reset mid-run: rst_i pulsed for one cycle after 20 counted cycles -> all snapshots, rd_data_o, ovf_o and halt_o = 0; counting restarts from 0.
